// File: rtl/d_bus_pkg.sv
// Shared definitions for the data-bus fabric: FSM state encoding, fault status
// bit positions and the default slot map.
package d_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } bus_state_t;

    localparam int FLT_UNMAPPED = 0;
    localparam int FLT_TIMEOUT  = 1;

    localparam int          DEF_NSLOT      = 4;
    localparam int          DEF_AW         = 16;
    localparam logic [63:0] DEF_SLOT_BASE  = {16'h2000, 16'h1080, 16'h1000, 16'h0000};
    localparam logic [63:0] DEF_SLOT_MASK  = {16'hF000, 16'hFFFF, 16'hFF80, 16'hF800};
    localparam logic [15:0] DEF_SLOT_WAIT  = {4'd0, 4'd1, 4'd0, 4'd0};
    localparam logic [7:0]  DEF_TIMEOUT    = 8'd64;
    localparam logic [15:0] DEF_FAULT_ADDR = 16'h10FE;

    // Index width that stays legal for a single entry.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/d_bus_decode.sv
// Combinational address decoder: maps an address onto one of NSLOT base/mask
// regions and reports hit, one-hot select and slot index.
module d_bus_decode
    import d_bus_pkg::*;
#(
    parameter int                  NSLOT     = DEF_NSLOT,
    parameter int                  AW        = DEF_AW,
    parameter int                  SW        = idx_w(NSLOT),
    parameter logic [NSLOT*AW-1:0] SLOT_BASE = DEF_SLOT_BASE,
    parameter logic [NSLOT*AW-1:0] SLOT_MASK = DEF_SLOT_MASK
) (
    input  logic [AW-1:0]    address,
    output logic             hit,
    output logic [NSLOT-1:0] sel,
    output logic [SW-1:0]    slot
);

    always_comb begin
        hit  = 1'b0;
        sel  = '0;
        slot = '0;
        // Scan from the top so the lowest-index match is the one left standing.
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if ((address & SLOT_MASK[i*AW +: AW]) == SLOT_BASE[i*AW +: AW]) begin
                hit    = 1'b1;
                sel    = '0;
                sel[i] = 1'b1;
                slot   = SW'(i);
            end
        end
    end

endmodule

// File: rtl/d_bus_fabric.sv
// Data-bus fabric between the CPU data port and its slaves: decode, strobe,
// wait states, slave ready, timeout watchdog and sticky fault registers.
module d_bus_fabric
    import d_bus_pkg::*;
#(
    parameter int                  NSLOT      = DEF_NSLOT,
    parameter int                  AW         = DEF_AW,
    parameter logic [NSLOT*AW-1:0] SLOT_BASE  = DEF_SLOT_BASE,
    parameter logic [NSLOT*AW-1:0] SLOT_MASK  = DEF_SLOT_MASK,
    parameter logic [NSLOT*4-1:0]  SLOT_WAIT  = DEF_SLOT_WAIT,
    parameter logic [7:0]          TIMEOUT    = DEF_TIMEOUT,
    parameter logic [AW-1:0]       FAULT_ADDR = DEF_FAULT_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      address,
    input  logic [7:0]         din,
    input  logic               w_en,
    input  logic               r_en,
    output logic [7:0]         dout,
    output logic               ready,
    output logic [NSLOT-1:0]   s_sel,
    output logic               s_w_en,
    output logic               s_r_en,
    output logic [AW-1:0]      s_addr,
    output logic [7:0]         s_din,
    input  logic [NSLOT*8-1:0] s_dout,
    input  logic [NSLOT-1:0]   s_ready,
    output logic               fault_flag,
    input  logic               fault_clr
);

    localparam int             SW    = idx_w(NSLOT);
    localparam int             TW    = idx_w(int'(TIMEOUT));
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 8'd1);

    bus_state_t     state;
    logic [SW-1:0]  slot;
    logic           is_write;
    logic [3:0]     wcnt;
    logic [TW-1:0]  tcnt;
    logic [1:0]     fault_kind;
    logic [AW-1:0]  fault_addr;

    logic             dec_hit;
    logic [NSLOT-1:0] dec_sel;
    logic [SW-1:0]    dec_slot;

    d_bus_decode #(
        .NSLOT     (NSLOT),
        .AW        (AW),
        .SW        (SW),
        .SLOT_BASE (SLOT_BASE),
        .SLOT_MASK (SLOT_MASK)
    ) u_decode (
        .address (address),
        .hit     (dec_hit),
        .sel     (dec_sel),
        .slot    (dec_slot)
    );

    logic [7:0] rd_bytes [NSLOT];
    logic [3:0] wait_tab [NSLOT];

    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            rd_bytes[i] = s_dout[i*8 +: 8];
            wait_tab[i] = SLOT_WAIT[i*4 +: 4];
        end
    end

    // Fault register window: +0 status, +1/+2 captured address bytes.
    logic        freg_hit;
    logic        freg_status;
    logic [7:0]  freg_rdata;
    logic [15:0] fault_addr_w;

    assign fault_addr_w = 16'(fault_addr);

    always_comb begin
        freg_hit    = 1'b1;
        freg_status = 1'b0;
        freg_rdata  = '0;
        if (address == FAULT_ADDR) begin
            freg_status = 1'b1;
            freg_rdata  = {6'b0, fault_kind};
        end else if (address == FAULT_ADDR + AW'(1)) begin
            freg_rdata = fault_addr_w[7:0];
        end else if (address == FAULT_ADDR + AW'(2)) begin
            freg_rdata = fault_addr_w[15:8];
        end else begin
            freg_hit = 1'b0;
        end
    end

    logic       req;
    logic       unmapped;
    logic       timed_out;
    logic       fault_set;
    logic       fault_wipe;
    logic [1:0] new_kind;

    assign req        = (state == ST_IDLE) && (w_en || r_en);
    assign unmapped   = req && !freg_hit && !dec_hit;
    assign timed_out  = (state == ST_WAIT) && (wcnt == 4'd0) && !s_ready[slot] && (tcnt == TLAST);
    assign fault_set  = unmapped || timed_out;
    assign fault_wipe = fault_clr || (req && freg_status && w_en);

    always_comb begin
        new_kind               = '0;
        new_kind[FLT_TIMEOUT]  = timed_out;
        new_kind[FLT_UNMAPPED] = unmapped;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            dout     <= '0;
            ready    <= 1'b0;
            s_sel    <= '0;
            s_w_en   <= 1'b0;
            s_r_en   <= 1'b0;
            s_addr   <= '0;
            s_din    <= '0;
            slot     <= '0;
            is_write <= 1'b0;
            wcnt     <= '0;
            tcnt     <= '0;
        end else begin
            ready  <= 1'b0;
            s_w_en <= 1'b0;
            s_r_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (w_en || r_en) begin
                        s_addr   <= address;
                        s_din    <= din;
                        is_write <= w_en;
                        slot     <= dec_slot;
                        wcnt     <= wait_tab[dec_slot];
                        tcnt     <= '0;
                        if (freg_hit) begin
                            dout  <= w_en ? 8'h00 : freg_rdata;
                            ready <= 1'b1;
                            state <= ST_DONE;
                        end else if (!dec_hit) begin
                            dout  <= 8'h00;
                            ready <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            // A simultaneous read+write request is a write.
                            s_sel  <= dec_sel;
                            s_w_en <= w_en;
                            s_r_en <= !w_en;
                            state  <= ST_STROBE;
                        end
                    end
                end
                ST_STROBE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else if (s_ready[slot]) begin
                        dout  <= is_write ? 8'h00 : rd_bytes[slot];
                        ready <= 1'b1;
                        s_sel <= '0;
                        state <= ST_DONE;
                    end else if (tcnt == TLAST) begin
                        dout  <= 8'hFF;
                        ready <= 1'b1;
                        s_sel <= '0;
                        state <= ST_DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A new fault outranks a clear in the same cycle; only the first is captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_flag <= 1'b0;
            fault_kind <= '0;
            fault_addr <= '0;
        end else if (fault_set) begin
            fault_flag <= 1'b1;
            if (!fault_flag) begin
                fault_kind <= new_kind;
                fault_addr <= timed_out ? s_addr : address;
            end
        end else if (fault_wipe) begin
            fault_flag <= 1'b0;
            fault_kind <= '0;
            fault_addr <= '0;
        end
    end

endmodule

// File: tb/tb_d_bus_fabric.sv
// Bench for d_bus_fabric: directed corner cases plus randomized transfers,
// each checked against a transaction-level model of the bus rules.
`timescale 1ns/1ps
module tb_d_bus_fabric;

    localparam int          NSLOT      = 4;
    localparam int          TIMEOUT    = 64;
    localparam int          NEVER      = 1000;
    localparam logic [15:0] FAULT_ADDR = 16'h10FE;

    logic                clk;
    logic                rst;
    logic [15:0]         address;
    logic [7:0]          din;
    logic                w_en;
    logic                r_en;
    logic [7:0]          dout;
    logic                ready;
    logic [NSLOT-1:0]    s_sel;
    logic                s_w_en;
    logic                s_r_en;
    logic [15:0]         s_addr;
    logic [7:0]          s_din;
    logic [NSLOT*8-1:0]  s_dout;
    logic [NSLOT-1:0]    s_ready;
    logic                fault_flag;
    logic                fault_clr;

    d_bus_fabric dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .din        (din),
        .w_en       (w_en),
        .r_en       (r_en),
        .dout       (dout),
        .ready      (ready),
        .s_sel      (s_sel),
        .s_w_en     (s_w_en),
        .s_r_en     (s_r_en),
        .s_addr     (s_addr),
        .s_din      (s_din),
        .s_dout     (s_dout),
        .s_ready    (s_ready),
        .fault_flag (fault_flag),
        .fault_clr  (fault_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slot map as a table: slot i answers when (addr & mask) == base.
    logic [15:0] base_tab [NSLOT] = '{16'h0000, 16'h1000, 16'h1080, 16'h2000};
    logic [15:0] mask_tab [NSLOT] = '{16'hF800, 16'hFF80, 16'hFFFF, 16'hF000};
    int          wait_tab [NSLOT] = '{0, 0, 1, 0};

    bit          m_flag;
    logic [1:0]  m_kind;
    logic [15:0] m_faddr;
    int          n_checks;
    int          n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_slot(input logic [15:0] a);
        for (int i = 0; i < NSLOT; i++)
            if ((a & mask_tab[i]) == base_tab[i]) return i;
        return -1;
    endfunction

    task automatic model_clear();
        m_flag  = 1'b0;
        m_kind  = 2'b00;
        m_faddr = 16'h0000;
    endtask

    // rdy_at: bench cycle from which the target slave raises s_ready.
    task automatic do_xfer(input logic [15:0] a, input logic [7:0] d, input bit wr, input bit rd,
                           input int rdy_at, input int fix, input bit clr_hold);
        int               sl, wt, first, exp_lat, lat, strobes, strobe_k, sel_bad, dir_bad;
        bit               is_freg, slot_xfer, flt, flt_timeout, seen;
        logic [7:0]       exp_dout, st_din;
        logic [15:0]      st_addr;
        logic [NSLOT-1:0] exp_sel;
        logic [7:0]       bytes [NSLOT];

        sl        = model_slot(a);
        is_freg   = (a == FAULT_ADDR) || (a == FAULT_ADDR + 16'd1) || (a == FAULT_ADDR + 16'd2);
        slot_xfer = !is_freg && (sl >= 0);
        for (int i = 0; i < NSLOT; i++) bytes[i] = (fix >= 0) ? 8'(fix) : 8'($urandom);

        flt = 0; flt_timeout = 0; exp_sel = '0; wt = 0;
        if (is_freg) begin
            exp_lat = 1;
            if (wr)                             exp_dout = 8'h00;
            else if (a == FAULT_ADDR)           exp_dout = {6'b0, m_kind};
            else if (a == FAULT_ADDR + 16'd1)   exp_dout = m_faddr[7:0];
            else                                exp_dout = m_faddr[15:8];
        end else if (sl < 0) begin
            exp_lat = 1; exp_dout = 8'h00; flt = 1;
        end else begin
            wt = wait_tab[sl];
            exp_sel[sl] = 1'b1;
            first = (rdy_at + 1 > 3 + wt) ? rdy_at + 1 : 3 + wt;
            if (first <= 2 + wt + TIMEOUT) begin
                exp_lat  = first;
                exp_dout = wr ? 8'h00 : bytes[sl];
            end else begin
                exp_lat = 2 + wt + TIMEOUT; exp_dout = 8'hFF; flt = 1; flt_timeout = 1;
            end
        end

        @(negedge clk);
        address = a; din = d; w_en = wr; r_en = rd; fault_clr = clr_hold;
        s_dout  = {bytes[3], bytes[2], bytes[1], bytes[0]};
        s_ready = 4'($urandom);
        if (sl >= 0) s_ready[sl] = (rdy_at <= 0);

        lat = 0; strobes = 0; strobe_k = 0; sel_bad = 0; dir_bad = 0; seen = 0;
        st_addr = '0; st_din = '0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(negedge clk);
            if (ready) begin
                seen = 1; lat = k;
            end else begin
                if (s_sel !== exp_sel) sel_bad++;
                if (s_w_en || s_r_en) begin
                    strobes++; strobe_k = k; st_addr = s_addr; st_din = s_din;
                    if (s_w_en !== wr || s_r_en !== !wr) dir_bad++;
                end
                s_ready = 4'($urandom);
                if (sl >= 0) s_ready[sl] = (k >= rdy_at);
            end
        end

        if (clr_hold && exp_lat > 1) model_clear();
        if (flt) begin
            if (!m_flag) begin
                m_kind  = flt_timeout ? 2'b10 : 2'b01;
                m_faddr = a;
            end
            m_flag = 1'b1;
        end else if (clr_hold || (is_freg && wr && a == FAULT_ADDR)) begin
            model_clear();
        end

        check_eq("ready_seen", seen, 1);
        if (seen) begin
            check_eq("latency", lat, exp_lat);
            check_eq("dout", dout, exp_dout);
            check_eq("sel_cleared", s_sel, 0);
            check_eq("fault_flag", fault_flag, m_flag);
            check_eq("sel_held", sel_bad, 0);
            check_eq("strobe_count", strobes, slot_xfer ? 1 : 0);
            if (slot_xfer && strobes == 1) begin
                check_eq("strobe_cycle", strobe_k, 1);
                check_eq("strobe_dir", dir_bad, 0);
                check_eq("s_addr", st_addr, a);
                if (wr) check_eq("s_din", st_din, d);
            end
        end
        w_en = 1'b0; r_en = 1'b0; fault_clr = 1'b0;
        @(negedge clk);
        check_eq("ready_pulse", ready, 0);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        model_clear();
        check_eq("clr_pulse", fault_flag, 0);
    endtask

    task automatic reset_mid_wait();
        int spurious;
        @(negedge clk);
        address = 16'h1010; din = 8'h5A; r_en = 1'b1; s_ready = '0;
        repeat (5) @(negedge clk);
        check_eq("wait_busy", ready, 0);
        rst = 1'b0;
        #1;
        check_eq("rst_outputs", {dout, ready, s_sel, s_w_en, s_r_en, fault_flag}, 0);
        check_eq("rst_fwd", {s_addr, s_din}, 0);
        r_en = 1'b0; s_ready = '1;
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        spurious = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready || s_w_en || s_r_en || s_sel != '0) spurious++;
        end
        check_eq("post_rst_idle", spurious, 0);
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 6))
            0:       return {5'b0, r[10:0]};
            1:       return 16'h1000 | {9'b0, r[6:0]};
            2:       return 16'h1080;
            3:       return 16'h2000 | {4'b0, r[11:0]};
            4:       return 16'h8000 | r;
            5:       return FAULT_ADDR + 16'($urandom_range(0, 2));
            default: return r;
        endcase
    endfunction

    initial begin
        n_checks = 0; n_fail = 0;
        model_clear();
        rst = 1'b0; address = '0; din = '0; w_en = 1'b0; r_en = 1'b0;
        s_dout = '0; s_ready = '1; fault_clr = 1'b0;
        #1;
        check_eq("reset_outputs", {dout, ready, s_sel, s_w_en, s_r_en, fault_flag}, 0);
        check_eq("reset_fwd", {s_addr, s_din}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        do_xfer(16'h0010, 8'h00, 0, 1, 0, 'hA5, 0);
        do_xfer(16'h1080, 8'h3C, 1, 0, 0, -1, 0);
        do_xfer(16'h8000, 8'h00, 0, 1, 0, -1, 0);
        do_xfer(FAULT_ADDR,         8'h00, 0, 1, 0, -1, 0);
        do_xfer(FAULT_ADDR + 16'd1, 8'h00, 0, 1, 0, -1, 0);
        do_xfer(FAULT_ADDR + 16'd2, 8'h00, 0, 1, 0, -1, 0);
        do_xfer(FAULT_ADDR,         8'h5E, 1, 0, 0, -1, 0);
        do_xfer(16'h1010, 8'h00, 0, 1, NEVER, -1, 0);
        do_xfer(FAULT_ADDR,         8'h00, 0, 1, 0, -1, 0);
        do_xfer(16'h9000, 8'h00, 0, 1, 0, -1, 0);
        do_xfer(FAULT_ADDR + 16'd1, 8'h00, 0, 1, 0, -1, 0);
        do_xfer(FAULT_ADDR + 16'd2, 8'h00, 0, 1, 0, -1, 0);
        pulse_clr();
        do_xfer(FAULT_ADDR,         8'h00, 0, 1, 0, -1, 0);
        do_xfer(16'hC000, 8'h00, 0, 1, 0, -1, 1);
        do_xfer(FAULT_ADDR + 16'd2, 8'h00, 0, 1, 0, -1, 0);
        do_xfer(FAULT_ADDR,         8'h00, 1, 0, 0, -1, 0);
        do_xfer(16'h0200, 8'h77, 1, 1, 0, -1, 0);
        do_xfer(16'h1085, 8'h00, 0, 1, 0, -1, 0);
        do_xfer(FAULT_ADDR,         8'h00, 1, 0, 0, -1, 0);
        do_xfer(16'h1040, 8'h00, 0, 1, 5, -1, 0);
        do_xfer(16'h1080, 8'h00, 0, 1, 0, -1, 0);
        do_xfer(16'h2ABC, 8'h00, 0, 1, 2, -1, 0);
        reset_mid_wait();

        for (int n = 0; n < 60; n++) begin
            bit wr, rd;
            int rdy;
            wr  = 1'($urandom);
            rd  = wr ? 1'($urandom) : 1'b1;
            rdy = ($urandom_range(0, 11) == 0) ? NEVER : int'($urandom_range(0, 8));
            do_xfer(rand_addr(), 8'($urandom), wr, rd, rdy, -1, 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        do_xfer(FAULT_ADDR, 8'h00, 0, 1, 0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
